// File: rtl/jk_pattern_driver.sv
// rtl/jk_pattern_driver.sv - drives an external JK flop through a target bit pattern
// Each bit takes three cycles (SETUP, APPLY, CHECK); j/k are only non-zero during APPLY.
module jk_pattern_driver #(
  parameter int WIDTH      = 8,
  parameter int USE_TOGGLE = 0
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic                       i_start,
  input  logic [WIDTH-1:0]           i_pattern,
  input  logic                       i_q,
  input  logic                       i_q_bar,
  output logic                       o_j,
  output logic                       o_k,
  output logic                       o_busy,
  output logic                       o_done,
  output logic                       o_err,
  output logic [$clog2(WIDTH+1)-1:0] o_err_count
);

  localparam int   CW  = $clog2(WIDTH + 1);
  localparam int   IW  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic TOG = (USE_TOGGLE != 0);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_APPLY = 3'd2,
    S_CHECK = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_shreg;
  logic [IW-1:0]    r_idx;
  logic             r_j;
  logic             r_k;
  logic             r_err;
  logic [CW-1:0]    r_err_count;

  logic w_t;
  logic w_j;
  logic w_k;
  logic w_last;
  logic w_mismatch;

  assign w_t    = r_shreg[0];
  assign w_last = (r_idx == IW'(WIDTH - 1));

  // Excitation from the live q so a drifted flop is pulled back on the next bit.
  assign w_j = (~i_q & w_t) | (TOG & i_q & ~w_t);
  assign w_k = (i_q & ~w_t) | (TOG & ~i_q & w_t);

  assign w_mismatch = (i_q != w_t) || (i_q_bar != ~i_q);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = i_start ? S_SETUP : S_IDLE;
      S_SETUP: w_next = S_APPLY;
      S_APPLY: w_next = S_CHECK;
      S_CHECK: w_next = w_last ? S_DONE : S_SETUP;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    o_busy      = (r_state == S_SETUP) || (r_state == S_APPLY) || (r_state == S_CHECK);
    o_done      = (r_state == S_DONE);
    o_j         = r_j;
    o_k         = r_k;
    o_err       = r_err;
    o_err_count = r_err_count;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_shreg     <= '0;
      r_idx       <= '0;
      r_j         <= 1'b0;
      r_k         <= 1'b0;
      r_err       <= 1'b0;
      r_err_count <= '0;
    end else begin
      r_j <= 1'b0;
      r_k <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_shreg     <= i_pattern;
            r_idx       <= '0;
            r_err       <= 1'b0;
            r_err_count <= '0;
          end
        end
        S_SETUP: begin
          r_j <= w_j;
          r_k <= w_k;
        end
        S_CHECK: begin
          if (w_mismatch) begin
            r_err <= 1'b1;
            if (r_err_count != CW'(WIDTH)) begin
              r_err_count <= r_err_count + 1'b1;
            end
          end
          if (!w_last) begin
            r_shreg <= r_shreg >> 1;
            r_idx   <= r_idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_jk_pattern_driver.sv
// tb/tb_jk_pattern_driver.sv - bench for jk_pattern_driver
// Two drivers (set/reset and toggle) each steer their own behavioural JK flop.
module tb_jk_pattern_driver;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] pattern;
  logic       ld;
  logic       ld_val;
  logic       stuck;
  logic       qbar_bad;
  logic       q0_reg;
  logic       q1_reg;
  logic       q0, qb0, q1, qb1;
  logic       j0, k0, busy0, done0, err0;
  logic       j1, k1, busy1, done1, err1;
  logic [3:0] cnt0, cnt1;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  assign q0  = stuck ? 1'b0 : q0_reg;
  assign qb0 = stuck ? 1'b1 : (qbar_bad ? q0 : ~q0);
  assign q1  = q1_reg;
  assign qb1 = ~q1_reg;

  always @(posedge clk) begin
    if (ld) q0_reg <= ld_val;
    else case ({j0, k0})
      2'b01:   q0_reg <= 1'b0;
      2'b10:   q0_reg <= 1'b1;
      2'b11:   q0_reg <= ~q0_reg;
      default: ;
    endcase
  end

  always @(posedge clk) begin
    if (ld) q1_reg <= ld_val;
    else case ({j1, k1})
      2'b01:   q1_reg <= 1'b0;
      2'b10:   q1_reg <= 1'b1;
      2'b11:   q1_reg <= ~q1_reg;
      default: ;
    endcase
  end

  jk_pattern_driver #(.WIDTH(8), .USE_TOGGLE(0)) u_dut_sr (
    .i_clk(clk), .i_reset(reset), .i_start(start), .i_pattern(pattern),
    .i_q(q0), .i_q_bar(qb0), .o_j(j0), .o_k(k0), .o_busy(busy0),
    .o_done(done0), .o_err(err0), .o_err_count(cnt0)
  );

  jk_pattern_driver #(.WIDTH(8), .USE_TOGGLE(1)) u_dut_tg (
    .i_clk(clk), .i_reset(reset), .i_start(start), .i_pattern(pattern),
    .i_q(q1), .i_q_bar(qb1), .o_j(j1), .o_k(k1), .o_busy(busy1),
    .o_done(done1), .o_err(err1), .o_err_count(cnt1)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  typedef struct {
    logic [7:0]  pat;
    logic        init_q;
    logic        stuck;
    int          bad_bit;
    logic [15:0] jk_sr;
    logic [15:0] jk_tg;
    int          err_sr;
    int          cnt_sr;
    int          fq_sr;
    int          fq_tg;
  } vec_t;

  vec_t vecs[5];

  // Starts a run, then samples every cycle m after the accepting edge.
  task automatic run_vec(input vec_t v, input int id);
    logic [15:0] seq0, seq1;
    int nz0, nz1, bb0, bb1, d0, d1, nd0, nd1;
    int e0, c0, e1, c1;
    string tag;
    tag = $sformatf("vec%0d", id);
    seq0 = '0; seq1 = '0;
    nz0 = 0; nz1 = 0; bb0 = 0; bb1 = 0; d0 = -1; d1 = -1; nd0 = 0; nd1 = 0;
    e0 = -1; c0 = -1; e1 = -1; c1 = -1;
    @(negedge clk);
    ld = 1'b1; ld_val = v.init_q; stuck = v.stuck; qbar_bad = 1'b0;
    @(negedge clk);
    ld = 1'b0; pattern = v.pat; start = 1'b1;
    @(negedge clk);
    start = 1'b0; pattern = ~v.pat;
    for (int m = 0; m < 30; m++) begin
      if (m % 3 == 1 && m < 24) begin
        seq0[2*(m/3) +: 2] = {j0, k0};
        seq1[2*(m/3) +: 2] = {j1, k1};
      end else begin
        if (j0 | k0) nz0++;
        if (j1 | k1) nz1++;
      end
      if (busy0 != (m < 24)) bb0++;
      if (busy1 != (m < 24)) bb1++;
      if (done0) begin nd0++; if (d0 < 0) d0 = m; end
      if (done1) begin nd1++; if (d1 < 0) d1 = m; end
      if (m == 24) begin e0 = err0; c0 = cnt0; e1 = err1; c1 = cnt1; end
      qbar_bad = (v.bad_bit >= 0) && (m == 3 * v.bad_bit + 2);
      start = (m == 7);
      @(negedge clk);
    end
    chk({tag, " jk_seq_sr"}, seq0, v.jk_sr);
    chk({tag, " jk_seq_tg"}, seq1, v.jk_tg);
    chk({tag, " jk_idle_sr"}, nz0, 0);
    chk({tag, " jk_idle_tg"}, nz1, 0);
    chk({tag, " busy_sr"}, bb0, 0);
    chk({tag, " busy_tg"}, bb1, 0);
    chk({tag, " done_cyc_sr"}, d0, 24);
    chk({tag, " done_cyc_tg"}, d1, 24);
    chk({tag, " done_cnt_sr"}, nd0, 1);
    chk({tag, " done_cnt_tg"}, nd1, 1);
    chk({tag, " err_sr"}, e0, v.err_sr);
    chk({tag, " cnt_sr"}, c0, v.cnt_sr);
    chk({tag, " err_tg"}, e1, 0);
    chk({tag, " cnt_tg"}, c1, 0);
    chk({tag, " final_q_sr"}, q0, v.fq_sr);
    chk({tag, " final_q_tg"}, q1, v.fq_tg);
  endtask

  initial begin
    int nd, nb, dfirst, dsecond, b25, b26;

    vecs[0] = '{8'b1010_0110, 1'b0, 1'b0, -1, 16'h9848, 16'hFCCC, 0, 0, 1, 1};
    vecs[1] = '{8'hFF,        1'b0, 1'b1, -1, 16'hAAAA, 16'h0003, 1, 8, 0, 1};
    vecs[2] = '{8'b1010_0110, 1'b0, 1'b0,  3, 16'h9848, 16'hFCCC, 1, 1, 1, 1};
    vecs[3] = '{8'h00,        1'b1, 1'b0, -1, 16'h0001, 16'h0003, 0, 0, 0, 0};
    vecs[4] = '{8'h55,        1'b0, 1'b0, -1, 16'h6666, 16'hFFFF, 0, 0, 0, 0};

    reset = 1'b1; start = 1'b0; pattern = '0;
    ld = 1'b1; ld_val = 1'b0; stuck = 1'b0; qbar_bad = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_ctl_sr", {j0, k0, busy0, done0, err0}, 0);
    chk("reset_cnt_sr", cnt0, 0);
    chk("reset_ctl_tg", {j1, k1, busy1, done1, err1}, 0);
    reset = 1'b0; ld = 1'b0;

    for (int i = 0; i < 5; i++) run_vec(vecs[i], i);

    // Abort a faulty run mid-flight; err was already set and must clear.
    @(negedge clk);
    ld = 1'b1; ld_val = 1'b0; stuck = 1'b1;
    @(negedge clk);
    ld = 1'b0; pattern = 8'hFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    chk("abort_err_before", err0, 1);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_ctl_sr", {j0, k0, busy0, done0, err0}, 0);
    chk("abort_cnt_sr", cnt0, 0);
    chk("abort_ctl_tg", {j1, k1, busy1, done1}, 0);
    @(negedge clk);
    reset = 1'b0;
    nd = 0; nb = 0;
    for (int m = 0; m < 30; m++) begin
      if (done0 | done1) nd++;
      if (busy0 | busy1) nb++;
      @(negedge clk);
    end
    chk("abort_no_done", nd, 0);
    chk("abort_no_busy", nb, 0);
    run_vec(vecs[0], 5);

    // Start held high: restarts only from IDLE.
    @(negedge clk);
    ld = 1'b1; ld_val = 1'b0; stuck = 1'b0;
    @(negedge clk);
    ld = 1'b0; pattern = 8'b1010_0110; start = 1'b1;
    @(negedge clk);
    dfirst = -1; dsecond = -1; b25 = -1; b26 = -1;
    for (int m = 0; m < 56; m++) begin
      if (done0) begin
        if (dfirst < 0) dfirst = m;
        else if (dsecond < 0) dsecond = m;
      end
      if (m == 25) b25 = busy0;
      if (m == 26) b26 = busy0;
      @(negedge clk);
    end
    start = 1'b0;
    chk("held_done_first", dfirst, 24);
    chk("held_done_second", dsecond, 50);
    chk("held_busy_idle", b25, 0);
    chk("held_busy_restart", b26, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
